// File: rtl/systolic_job_ctrl.sv
// rtl/systolic_job_ctrl.sv - job sequencer for a 3x3 output-stationary systolic array
//
// Accepts one pair of 3x3 operand matrices per job, registers the skewed west/north
// feed vectors, holds the array in reset for CLR_CYC cycles, releases it and waits
// for arr_done (bounded by TIMEOUT RUN cycles), then offers the captured 9-element
// result downstream.
//
// Optional build macro: SA_PERF_CNT_EN adds perf_cycles (RUN cycles of the last job).
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready        job handshake; a_in, b_in row-major 3x3 operands
//   west_0..2, north_0..2    skewed feed vectors, slot k at [k*DW +: DW]
//   arr_rst                  active-high array reset
//   arr_out, arr_done        array result and completion
//   res_valid/res_ready      result handshake; res_data captured result
//   busy                     controller not idle
//   timeout_err              sticky: last job aborted on timeout
//   perf_cycles              (SA_PERF_CNT_EN only) RUN-cycle count of last capture
module systolic_job_ctrl #(
    parameter int DW      = 16,
    parameter int OW      = 32,
    parameter int CLR_CYC = 2,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [9*DW-1:0] a_in,
    input  logic [9*DW-1:0] b_in,
    output logic [5*DW-1:0] west_0,
    output logic [5*DW-1:0] west_1,
    output logic [5*DW-1:0] west_2,
    output logic [5*DW-1:0] north_0,
    output logic [5*DW-1:0] north_1,
    output logic [5*DW-1:0] north_2,
    output logic            arr_rst,
    input  logic [9*OW-1:0] arr_out,
    input  logic            arr_done,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [9*OW-1:0] res_data,
    output logic            busy,
    output logic            timeout_err
`ifdef SA_PERF_CNT_EN
    ,
    output logic [15:0]     perf_cycles
`endif
);

    localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam int RW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   clr_cnt;
    logic [RW-1:0]   run_cnt;
    logic [RW-1:0]   run_next;
    logic            clr_last;
    logic            accept;
    logic            capture;
    logic            abort;

    logic [5*DW-1:0] west_d  [3];
    logic [5*DW-1:0] north_d [3];
    logic [5*DW-1:0] west_q  [3];
    logic [5*DW-1:0] north_q [3];
    logic [9*OW-1:0] res_q;

    // Skew: row/column r is delayed by r slots so matching operand pairs meet
    // in PE(i,j) on the same cycle.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            west_d[r]  = '0;
            north_d[r] = '0;
            for (int k = 0; k < 5; k++) begin
                if (k >= r && k - r <= 2) begin
                    west_d[r][k*DW +: DW]  = a_in[(3*r + (k - r))*DW +: DW];
                    north_d[r][k*DW +: DW] = b_in[(3*(k - r) + r)*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        clr_last = (clr_cnt == CW'(CLR_CYC - 1));
        run_next = run_cnt + RW'(1);
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // done takes priority over a coincident timeout
                if (arr_done) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else if (run_next == RW'(TIMEOUT)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt     <= '0;
            run_cnt     <= '0;
            res_q       <= '0;
            timeout_err <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                west_q[r]  <= '0;
                north_q[r] <= '0;
            end
        end else begin
            if (accept) begin
                clr_cnt     <= '0;
                run_cnt     <= '0;
                timeout_err <= 1'b0;
                for (int r = 0; r < 3; r++) begin
                    west_q[r]  <= west_d[r];
                    north_q[r] <= north_d[r];
                end
            end
            if (state_q == CLEAR && !clr_last) begin
                clr_cnt <= clr_cnt + CW'(1);
            end
            if (state_q == RUN) begin
                run_cnt <= run_next;
            end
            if (capture) begin
                res_q <= arr_out;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef SA_PERF_CNT_EN
    logic [31:0] run_ext;
    assign run_ext = 32'(run_cnt) + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
        end else if (capture) begin
            perf_cycles <= (run_ext > 32'h0000_FFFF) ? 16'hFFFF : run_ext[15:0];
        end
    end
`endif

    // rst gating keeps in_ready low for the whole time reset is asserted
    assign in_ready  = rst && (state_q == IDLE);
    assign arr_rst   = (state_q != RUN);
    assign res_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_q;
    assign west_0    = west_q[0];
    assign west_1    = west_q[1];
    assign west_2    = west_q[2];
    assign north_0   = north_q[0];
    assign north_1   = north_q[1];
    assign north_2   = north_q[2];

endmodule

// File: tb/tb_systolic_job_ctrl.sv
// tb/tb_systolic_job_ctrl.sv - self-checking bench for systolic_job_ctrl
module tb_systolic_job_ctrl;

    localparam int DW = 16;
    localparam int OW = 32;
    localparam int RDW = 9 * OW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [9*DW-1:0] a_in = '0;
    logic [9*DW-1:0] b_in = '0;
    logic [5*DW-1:0] west_0, west_1, west_2, north_0, north_1, north_2;
    logic            arr_rst;
    logic [RDW-1:0]  arr_out;
    logic            arr_done;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [RDW-1:0]  res_data;
    logic            busy;
    logic            timeout_err;
`ifdef SA_PERF_CNT_EN
    logic [15:0]     perf_cycles;
`endif

    systolic_job_ctrl #(.DW(DW), .OW(OW), .CLR_CYC(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .west_0(west_0), .west_1(west_1), .west_2(west_2),
        .north_0(north_0), .north_1(north_1), .north_2(north_2),
        .arr_rst(arr_rst), .arr_out(arr_out), .arr_done(arr_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .timeout_err(timeout_err)
`ifdef SA_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    // mode 0: behavioural array, 1: stub done at stub_at-th RUN cycle (0 = never), 2: done stuck high
    int             mode = 0;
    int             stub_at = 0;
    int             stub_cnt = 0;
    logic [RDW-1:0] stub_data = '0;

    logic [5*DW-1:0] w_arr [3];
    logic [5*DW-1:0] n_arr [3];
    assign w_arr[0] = west_0;
    assign w_arr[1] = west_1;
    assign w_arr[2] = west_2;
    assign n_arr[0] = north_0;
    assign n_arr[1] = north_1;
    assign n_arr[2] = north_2;

    logic [OW-1:0]  acc [9];
    logic [RDW-1:0] acc_flat;
    int             mt = 0;
    logic           m_done = 1'b0;

    // output-stationary array: PE(i,j) sees west_i slot t-j and north_j slot t-i at step t
    always @(posedge clk) begin
        if (arr_rst) begin
            mt     <= 0;
            m_done <= 1'b0;
            for (int i = 0; i < 9; i++) acc[i] <= '0;
        end else if (!m_done) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    if (mt - i - j >= 0 && mt - i - j <= 2) begin
                        acc[3*i+j] <= acc[3*i+j]
                            + 32'(w_arr[i][(mt-j)*DW +: DW]) * 32'(n_arr[j][(mt-i)*DW +: DW]);
                    end
                end
            end
            mt <= mt + 1;
            if (mt == 6) m_done <= 1'b1;
        end
    end

    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < 9; i++) acc_flat[i*OW +: OW] = acc[i];
    end

    always @(posedge clk) begin
        if (arr_rst) stub_cnt <= 0;
        else         stub_cnt <= stub_cnt + 1;
    end

    assign arr_out  = (mode == 0) ? acc_flat : stub_data;
    assign arr_done = (mode == 0) ? m_done :
                      (mode == 2) ? 1'b1 :
                      (stub_at != 0 && stub_cnt + 1 == stub_at);

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [RDW-1:0] obs, input logic [RDW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [RDW-1:0] sb [$];
    logic [RDW-1:0] last_res = '0;

    int mat_a [9] = '{1, 3, 4, 5, 8, 9, 7, 4, 5};
    int mat_b [9] = '{7, 8, 2, 3, 6, 7, 4, 7, 3};

    function automatic logic [RDW-1:0] matmul(input int a [9], input int b [9]);
        logic [RDW-1:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++) s += a[3*i+k] * b[3*k+j];
                r[(3*i+j)*OW +: OW] = 32'(s);
            end
        return r;
    endfunction

    task automatic rand_stub();
        for (int i = 0; i < 9; i++) stub_data[i*OW +: OW] = $urandom;
    endtask

    // Called at a negedge in IDLE; returns at the first negedge after the accept edge.
    task automatic offer(input string tag);
        check({tag, "_in_ready"}, RDW'(in_ready), RDW'(1));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, RDW'(busy), RDW'(1));
    endtask

    // Index 1 = first negedge after the accept edge.
    task automatic watch(output int low_at, output int valid_at, output int runs);
        low_at = 0;
        valid_at = 0;
        runs = 0;
        for (int i = 1; i <= 200; i++) begin
            if (!arr_rst) begin
                runs++;
                if (low_at == 0) low_at = i;
            end
            if (res_valid) begin
                valid_at = i;
                break;
            end
            if (timeout_err) break;
            @(negedge clk);
        end
    endtask

    task automatic consume(input string tag, input int hold);
        logic [RDW-1:0] d0;
        logic [RDW-1:0] exp;
        d0 = res_data;
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, RDW'(res_valid), RDW'(1));
            check({tag, "_hold_in_ready"}, RDW'(in_ready), RDW'(0));
            check({tag, "_hold_stable"}, res_data, d0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, RDW'(0), RDW'(1));
        end else begin
            exp = sb.pop_front();
            check({tag, "_res_data"}, res_data, exp);
        end
        last_res = res_data;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, RDW'(res_valid), RDW'(0));
        check({tag, "_idle_ready"}, RDW'(in_ready), RDW'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, va, rn;

        repeat (3) @(negedge clk);
        check("rst_arr_rst", RDW'(arr_rst), RDW'(1));
        check("rst_in_ready", RDW'(in_ready), RDW'(0));
        check("rst_busy", RDW'(busy), RDW'(0));
        check("rst_res_valid", RDW'(res_valid), RDW'(0));
        check("rst_timeout", RDW'(timeout_err), RDW'(0));
        check("rst_res_data", res_data, RDW'(0));
        check("rst_west_0", RDW'(west_0), RDW'(0));
        rst = 1'b1;
        @(negedge clk);

        // job 1: real array model, skew vectors and end-to-end result
        for (int i = 0; i < 9; i++) begin
            a_in[i*DW +: DW] = DW'(mat_a[i]);
            b_in[i*DW +: DW] = DW'(mat_b[i]);
        end
        mode = 0;
        sb.push_back(matmul(mat_a, mat_b));
        offer("j1");
        check("skew_west_0",  RDW'(west_0),  RDW'({16'd0, 16'd0, 16'd4, 16'd3, 16'd1}));
        check("skew_west_1",  RDW'(west_1),  RDW'({16'd0, 16'd9, 16'd8, 16'd5, 16'd0}));
        check("skew_west_2",  RDW'(west_2),  RDW'({16'd5, 16'd4, 16'd7, 16'd0, 16'd0}));
        check("skew_north_0", RDW'(north_0), RDW'({16'd0, 16'd0, 16'd4, 16'd3, 16'd7}));
        check("skew_north_1", RDW'(north_1), RDW'({16'd0, 16'd7, 16'd6, 16'd8, 16'd0}));
        check("skew_north_2", RDW'(north_2), RDW'({16'd3, 16'd7, 16'd2, 16'd0, 16'd0}));
        watch(lo, va, rn);
        check("j1_release_at", RDW'(lo), RDW'(3));
        check("j1_valid_seen", RDW'(va != 0), RDW'(1));
        if (va != 0) consume("j1", 5);

        // job 2: stub done in 3rd RUN cycle
        mode = 1;
        stub_at = 3;
        rand_stub();
        sb.push_back(stub_data);
        offer("j2");
        watch(lo, va, rn);
        check("j2_release_at", RDW'(lo), RDW'(3));
        check("j2_valid_at", RDW'(va), RDW'(6));
`ifdef SA_PERF_CNT_EN
        check("j2_perf", RDW'(perf_cycles), RDW'(3));
`endif
        if (va != 0) consume("j2", 1);

        // job 3: never done -> timeout
        stub_at = 0;
        offer("j3");
        watch(lo, va, rn);
        check("j3_run_cycles", RDW'(rn), RDW'(64));
        check("j3_no_valid", RDW'(va), RDW'(0));
        check("j3_timeout_err", RDW'(timeout_err), RDW'(1));
        check("j3_in_ready", RDW'(in_ready), RDW'(1));
        check("j3_res_kept", res_data, last_res);

        // job 4: next accept clears timeout_err; done in first RUN cycle
        stub_at = 1;
        rand_stub();
        sb.push_back(stub_data);
        offer("j4");
        check("j4_timeout_clr", RDW'(timeout_err), RDW'(0));
        watch(lo, va, rn);
        check("j4_valid_at", RDW'(va), RDW'(4));
        if (va != 0) consume("j4", 0);

        // job 5: done stuck high, must be ignored during CLEAR
        mode = 2;
        rand_stub();
        sb.push_back(stub_data);
        offer("j5");
        watch(lo, va, rn);
        check("j5_valid_at", RDW'(va), RDW'(4));
`ifdef SA_PERF_CNT_EN
        check("j5_perf", RDW'(perf_cycles), RDW'(1));
`endif
        if (va != 0) consume("j5", 2);

        // job 6: done on the TIMEOUT cycle wins
        mode = 1;
        stub_at = 64;
        rand_stub();
        sb.push_back(stub_data);
        offer("j6");
        watch(lo, va, rn);
        check("j6_valid_at", RDW'(va), RDW'(67));
        check("j6_no_timeout", RDW'(timeout_err), RDW'(0));
`ifdef SA_PERF_CNT_EN
        check("j6_perf", RDW'(perf_cycles), RDW'(64));
`endif
        if (va != 0) consume("j6", 0);

        // job 7: reset mid-RUN
        stub_at = 0;
        offer("j7");
        repeat (4) @(negedge clk);
        check("j7_in_run", RDW'(arr_rst), RDW'(0));
        #2;
        rst = 1'b0;
        #1;
        check("j7_arst_arr_rst", RDW'(arr_rst), RDW'(1));
        check("j7_arst_busy", RDW'(busy), RDW'(0));
        check("j7_arst_in_ready", RDW'(in_ready), RDW'(0));
        check("j7_arst_res_data", res_data, RDW'(0));
        check("j7_arst_west_1", RDW'(west_1), RDW'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("j7_post_in_ready", RDW'(in_ready), RDW'(1));
        check("j7_post_res_valid", RDW'(res_valid), RDW'(0));
        check("j7_post_timeout", RDW'(timeout_err), RDW'(0));

        check("sb_drained", RDW'(sb.size()), RDW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
